// File: rtl/noc_pkg.sv
// Shared router definitions: flit-type field location/encoding and the
// input-requester state encoding.
`ifndef NOC_PKG_SV
`define NOC_PKG_SV

`define NOC_FT_HI(dw) ((dw) - 1)
`define NOC_FT_LO(dw) ((dw) - 2)

package noc_pkg;

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DROP   = 2'd2;

  function automatic logic ft_opens(input logic [1:0] ft);
    return (ft == FT_HEAD) || (ft == FT_SINGLE);
  endfunction

  function automatic logic ft_closes(input logic [1:0] ft);
    return (ft == FT_TAIL) || (ft == FT_SINGLE);
  endfunction

endpackage

`endif

// File: rtl/noc_flit_fifo.sv
// Small flit FIFO with wrap-bit pointers; head is read combinationally.
module noc_flit_fifo
  import noc_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_empty,
  output logic [DW-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [DW-1:0] r_mem [DEPTH];
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty = (r_wptr == r_rptr);
  assign o_head  = r_mem[r_rptr[AW-1:0]];

  // A push at full is refused even if a pop frees a slot in the same cycle.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/noc_input_requester.sv
// Router input port: buffers wormhole flits, requests the decoded output,
// streams the packet while granted and releases the arbiter on the tail.
//
// state  | meaning
// IDLE   | waiting for a packet head at the FIFO head
// ACTIVE | request held, flits sent on grant && out_ready until the tail
// DROP   | malformed packet being discarded up to its tail
module noc_input_requester
  import noc_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int NPORT = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_flit,
  output logic             in_ready,
  output logic [NPORT-1:0] request,
  input  logic [NPORT-1:0] grant,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_flit,
  output logic [NPORT-1:0] pkt_release,
  output logic             err
);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [NPORT-1:0] r_req;
  logic [NPORT-1:0] w_req_nxt;
  logic             w_full;
  logic             w_empty;
  logic [DW-1:0]    w_head;
  logic             w_pop;
  logic             w_fire;
  logic             w_err;
  logic [NPORT-1:0] w_release;
  logic [1:0]       w_ftype;
  logic [NPORT-1:0] w_dest;
  logic             w_dest_onehot;

  noc_flit_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (in_valid),
    .i_wdata (in_flit),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign w_ftype       = w_head[`NOC_FT_HI(DW):`NOC_FT_LO(DW)];
  assign w_dest        = w_head[NPORT-1:0];
  assign w_dest_onehot = (w_dest != '0) && ((w_dest & (w_dest - NPORT'(1))) == '0);

  assign w_fire = (r_state == ST_ACTIVE) && !w_empty && (|(r_req & grant)) && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_pop       = 1'b0;
    w_err       = 1'b0;
    w_release   = '0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          if (ft_opens(w_ftype)) begin
            if (w_dest_onehot) begin
              w_state_nxt = ST_ACTIVE;
              w_req_nxt   = w_dest;
            end else begin
              // head stays queued; DROP pops it along with the rest
              w_state_nxt = ST_DROP;
              w_err       = 1'b1;
            end
          end else begin
            w_pop = 1'b1;
            w_err = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (w_fire) begin
          w_pop = 1'b1;
          if (ft_closes(w_ftype)) begin
            w_release   = r_req;
            w_state_nxt = ST_IDLE;
            w_req_nxt   = '0;
          end
        end
      end
      ST_DROP: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (ft_closes(w_ftype)) w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_req_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_req   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
    end
  end

  assign in_ready    = !w_full;
  assign request     = r_req;
  assign out_valid   = w_fire;
  assign out_flit    = w_head;
  assign pkt_release = w_release;
  assign err         = w_err;

endmodule

// File: tb/tb_noc_input_requester.sv
// Directed scenarios plus random packet traffic, checked every cycle against a
// packet-level queue model of the input port.
`timescale 1ns/1ps
module tb_noc_input_requester;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int NPORT = 5;

  logic             clk = 1'b0;
  logic             rstn;
  logic             in_valid;
  logic [DW-1:0]    in_flit;
  logic             in_ready;
  logic [NPORT-1:0] request;
  logic [NPORT-1:0] grant;
  logic             out_ready;
  logic             out_valid;
  logic [DW-1:0]    out_flit;
  logic [NPORT-1:0] pkt_release;
  logic             err;

  noc_input_requester #(.DW(DW), .DEPTH(DEPTH), .NPORT(NPORT)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_flit     (in_flit),
    .in_ready    (in_ready),
    .request     (request),
    .grant       (grant),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_flit    (out_flit),
    .pkt_release (pkt_release),
    .err         (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // reference model: queued flits plus packet-level mode (0 idle, 1 sending, 2 discarding)
  logic [DW-1:0]    m_q[$];
  int               m_mode = 0;
  logic [NPORT-1:0] m_dest = '0;

  // stimulus state
  logic [DW-1:0]    src[$];
  logic [NPORT-1:0] g_seq[$];
  logic [NPORT-1:0] g_fixed = '0;
  bit               g_rand  = 0;
  bit               gen_on  = 0;
  int               vld_pct = 100;
  int               or_pct  = 100;
  int               ov_cnt  = 0;
  int               rel_cnt = 0;
  int               err_cnt = 0;

  function automatic logic [DW-1:0] mk(input logic [1:0] ft, input logic [NPORT-1:0] dest);
    return {ft, 25'($urandom), dest};
  endfunction

  function automatic logic [NPORT-1:0] bad_dest();
    logic [NPORT-1:0] d;
    d = NPORT'($urandom);
    while ($countones(d) == 1) d = NPORT'($urandom);
    return d;
  endfunction

  task automatic add_pkt(input int len, input logic [NPORT-1:0] dest);
    if (len == 1) src.push_back(mk(2'b11, dest));
    else begin
      src.push_back(mk(2'b01, dest));
      for (int i = 1; i < len - 1; i++) src.push_back(mk(2'b00, NPORT'($urandom)));
      src.push_back(mk(2'b10, NPORT'($urandom)));
    end
  endtask

  task automatic gen_pkt();
    int k;
    k = $urandom_range(9);
    if (k < 6)       add_pkt($urandom_range(1, 5), NPORT'(1 << $urandom_range(NPORT - 1)));
    else if (k == 6) add_pkt($urandom_range(2, 4), bad_dest());
    else if (k == 7) add_pkt(1, bad_dest());
    else if (k == 8) src.push_back(mk(2'b00, NPORT'($urandom)));
    else             src.push_back(mk(2'b10, NPORT'($urandom)));
  endtask

  task automatic drive();
    if (gen_on && src.size() < 3) gen_pkt();
    in_valid = (src.size() > 0) && ($urandom_range(99) < vld_pct);
    in_flit  = (src.size() > 0) ? src[0] : DW'($urandom);
    if (g_seq.size() > 0) grant = g_seq.pop_front();
    else if (g_rand)      grant = NPORT'($urandom);
    else                  grant = g_fixed;
    out_ready = ($urandom_range(99) < or_pct);
  endtask

  // one clock: drive after the edge, check and advance the model mid-cycle
  task automatic tick();
    int               sz;
    logic [DW-1:0]    head;
    logic [1:0]       ft;
    logic [NPORT-1:0] e_req;
    logic [NPORT-1:0] e_rel;
    bit               e_fire, e_err, pop, push;
    drive();
    @(negedge clk);
    sz     = m_q.size();
    head   = (sz > 0) ? m_q[0] : '0;
    ft     = head[DW-1:DW-2];
    e_req  = (m_mode == 1) ? m_dest : '0;
    e_rel  = '0;
    e_fire = 0;
    e_err  = 0;
    pop    = 0;
    if (m_mode == 0) begin
      if (sz > 0) begin
        if (ft == 2'b01 || ft == 2'b11) begin
          if ($countones(head[NPORT-1:0]) == 1) begin
            m_mode = 1;
            m_dest = head[NPORT-1:0];
          end else begin
            e_err  = 1;
            m_mode = 2;
          end
        end else begin
          e_err = 1;
          pop   = 1;
        end
      end
    end else if (m_mode == 1) begin
      e_fire = (sz > 0) && ((m_dest & grant) != 0) && out_ready;
      if (e_fire) begin
        pop = 1;
        chk("out_flit", out_flit, head);
        if (ft[1]) begin
          e_rel  = m_dest;
          m_mode = 0;
          m_dest = '0;
        end
      end
    end else begin
      if (sz > 0) begin
        pop = 1;
        if (ft[1]) m_mode = 0;
      end
    end
    chk("in_ready", in_ready, (sz < DEPTH));
    chk("request", request, e_req);
    chk("out_valid", out_valid, e_fire);
    chk("release", pkt_release, e_rel);
    chk("err", err, e_err);
    if (out_valid) ov_cnt++;
    if (|pkt_release) rel_cnt++;
    if (err) err_cnt++;
    push = in_valid && (sz < DEPTH);
    if (pop) void'(m_q.pop_front());
    if (push) begin
      m_q.push_back(in_flit);
      void'(src.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_cnt();
    ov_cnt  = 0;
    rel_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    m_q.delete();
    src.delete();
    g_seq.delete();
    m_mode = 0;
    m_dest = '0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_request", request, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_release", pkt_release, 0);
    chk("rst_err", err, 0);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit drained;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_flit   = '0;
    grant     = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // single-flit packet to port 2
    clr_cnt();
    g_fixed = 5'b00100;
    add_pkt(1, 5'b00100);
    run(6);
    chk("s1_ov", ov_cnt, 1);
    chk("s1_rel", rel_cnt, 1);

    // 4-flit packet to port 1 with a grant gap
    clr_cnt();
    g_fixed = '0;
    add_pkt(4, 5'b00010);
    g_seq = '{5'b0, 5'b0, 5'b00010, 5'b0, 5'b00010, 5'b00010, 5'b00010};
    run(10);
    chk("s2_ov", ov_cnt, 4);
    chk("s2_rel", rel_cnt, 1);

    // fill past depth with the output blocked, then drain
    clr_cnt();
    or_pct  = 0;
    g_fixed = 5'b01000;
    add_pkt(5, 5'b01000);
    run(8);
    chk("s3_full", in_ready, 0);
    or_pct = 100;
    run(10);
    chk("s3_ov", ov_cnt, 5);

    // bad destination packet then a valid single
    clr_cnt();
    g_fixed = '1;
    add_pkt(3, 5'b00110);
    add_pkt(1, 5'b00001);
    run(12);
    chk("s4_err", err_cnt, 1);
    chk("s4_ov", ov_cnt, 1);

    // stray body then a valid two-flit packet
    clr_cnt();
    src.push_back(mk(2'b00, 5'b00001));
    add_pkt(2, 5'b10000);
    run(10);
    chk("s5_err", err_cnt, 1);
    chk("s5_ov", ov_cnt, 2);

    // reset in the middle of a packet, then a fresh single
    g_fixed = 5'b00100;
    add_pkt(4, 5'b00100);
    run(3);
    do_reset();
    clr_cnt();
    g_fixed = 5'b00001;
    add_pkt(1, 5'b00001);
    run(6);
    chk("s6_ov", ov_cnt, 1);
    chk("s6_rel", rel_cnt, 1);

    // random traffic
    gen_on  = 1;
    g_rand  = 1;
    vld_pct = 80;
    or_pct  = 70;
    run(4000);

    // drain
    gen_on  = 0;
    g_rand  = 0;
    g_fixed = '1;
    vld_pct = 100;
    or_pct  = 100;
    drained = 0;
    for (int i = 0; i < 200 && !drained; i++) begin
      tick();
      drained = (src.size() == 0) && (m_q.size() == 0) && (m_mode == 0);
    end
    chk("drain", drained, 1);
    chk("end_request", request, 0);
    chk("end_in_ready", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
